// File: rtl/fft_in_buffer.sv
// fft_in_buffer
//   Collects a stream of real input samples into one FFT frame of N_POINTS
//   complex slots. Each sample is extended (zero or sign per SIGNED_IN),
//   scaled by FIX_BIT fractional bits and stored as the real part of a slot.
//   The imaginary part is zero. Slots are filled in bit-reversed order when
//   BIT_REV=1, natural order otherwise. A completed frame is held on
//   frame_data until the FFT core takes it with frame_valid && frame_ready.
//   A frame that ends early (s_last before the final slot) is dropped and
//   reported with a one-cycle err pulse.
//
// Ports
//   clk          single clock, rising edge
//   rst          asynchronous active-high reset
//   s_valid      input sample valid
//   s_ready      block accepts a sample this cycle (state FILL)
//   s_data       input sample, IN_W bits
//   s_last       last sample of a frame, qualified by s_valid && s_ready
//   flush        synchronous abort of the current frame
//   frame_valid  complete frame held on frame_data (state FULL)
//   frame_ready  FFT core consumes the frame
//   frame_data   slot k at [(k+1)*2*BITS-1 : k*2*BITS], imag upper, real lower
//   err          one-cycle pulse after a short frame
module fft_in_buffer #(
    parameter int unsigned N_POINTS  = 32,
    parameter int unsigned IN_W      = 8,
    parameter int unsigned BITS      = 16,
    parameter int unsigned FIX_BIT   = 7,
    parameter int unsigned SIGNED_IN = 0,
    parameter int unsigned BIT_REV   = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [IN_W-1:0]              s_data,
    input  logic                         s_last,
    input  logic                         flush,
    output logic                         frame_valid,
    input  logic                         frame_ready,
    output logic [N_POINTS*2*BITS-1:0]   frame_data,
    output logic                         err
);

    localparam int unsigned CW = $clog2(N_POINTS);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            err_nxt;
    logic            accept;
    logic            last_slot;
    logic [CW-1:0]   wr_idx;
    logic signed [IN_W:0] s_ext;
    logic [BITS-1:0] conv_ext;
    logic [BITS-1:0] conv;

    // Only the real part is stored; the imaginary part of every slot is zero.
    logic [BITS-1:0] slot_re [N_POINTS];

    function automatic logic [CW-1:0] bitrev(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < CW; i++) begin
            r[i] = v[CW-1-i];
        end
        return r;
    endfunction

    assign s_ready     = (state == FILL);
    assign frame_valid = (state == FULL);

    // Flush wins over a same-cycle sample, so such a sample is never written.
    assign accept    = s_valid && s_ready && !flush;
    assign last_slot = (cnt == CW'(N_POINTS - 1));
    assign wr_idx    = (BIT_REV != 0) ? bitrev(cnt) : cnt;

    // One extra bit carries the chosen extension; the signed size cast then
    // replicates it up to BITS before scaling.
    always_comb begin
        if (SIGNED_IN != 0) begin
            s_ext = {s_data[IN_W-1], s_data};
        end else begin
            s_ext = {1'b0, s_data};
        end
        conv_ext = BITS'(s_ext);
        conv     = conv_ext << FIX_BIT;
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        err_nxt   = 1'b0;
        if (flush) begin
            state_nxt = FILL;
            cnt_nxt   = '0;
        end else begin
            case (state)
                FILL: begin
                    if (s_valid) begin
                        if (last_slot) begin
                            cnt_nxt   = '0;
                            state_nxt = FULL;
                        end else if (s_last) begin
                            cnt_nxt = '0;
                            err_nxt = 1'b1;
                        end else begin
                            cnt_nxt = cnt + CW'(1);
                        end
                    end
                end
                FULL: begin
                    if (frame_ready) begin
                        state_nxt = FILL;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FILL;
            cnt   <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            err   <= err_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < N_POINTS; k++) begin
                slot_re[k] <= '0;
            end
        end else if (accept) begin
            slot_re[wr_idx] <= conv;
        end
    end

    always_comb begin
        frame_data = '0;
        for (int unsigned k = 0; k < N_POINTS; k++) begin
            frame_data[k*2*BITS +: BITS] = slot_re[k];
        end
    end

endmodule

// File: tb/tb_fft_in_buffer.sv
// tb_fft_in_buffer
//   Two instances share one stimulus stream: u0 uses the defaults (unsigned,
//   bit-reversed), u1 is signed with natural slot order. A reference model
//   collects accepted samples in a queue and, when a frame completes, pushes
//   the expected frame word for each instance onto a scoreboard queue. A
//   monitor pops an expected frame when frame_valid rises and compares it on
//   every cycle the frame is held; handshake outputs and err are compared
//   every cycle against the model.
module tb_fft_in_buffer;

    localparam int N    = 32;
    localparam int IN_W = 8;
    localparam int BITS = 16;
    localparam int FIX  = 7;
    localparam int FW   = N * 2 * BITS;

    logic            clk;
    logic            rst;
    logic            s_valid;
    logic [IN_W-1:0] s_data;
    logic            s_last;
    logic            flush;
    logic            frame_ready;
    logic            r0, r1, fv0, fv1, err0, err1;
    logic [FW-1:0]   fd0, fd1;

    int checks;
    int failures;

    fft_in_buffer #(
        .N_POINTS(N), .IN_W(IN_W), .BITS(BITS), .FIX_BIT(FIX),
        .SIGNED_IN(0), .BIT_REV(1)
    ) u0 (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(r0),
        .s_data(s_data), .s_last(s_last), .flush(flush),
        .frame_valid(fv0), .frame_ready(frame_ready),
        .frame_data(fd0), .err(err0)
    );

    fft_in_buffer #(
        .N_POINTS(N), .IN_W(IN_W), .BITS(BITS), .FIX_BIT(FIX),
        .SIGNED_IN(1), .BIT_REV(0)
    ) u1 (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(r1),
        .s_data(s_data), .s_last(s_last), .flush(flush),
        .frame_valid(fv1), .frame_ready(frame_ready),
        .frame_data(fd1), .err(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [IN_W-1:0] cur[$];
    logic [FW-1:0]   q0[$];
    logic [FW-1:0]   q1[$];
    bit              m_full;
    bit              m_err;

    function automatic logic [BITS-1:0] conv(input logic [IN_W-1:0] v, input bit sgn);
        int          x;
        logic [31:0] t;
        if (sgn) x = int'($signed(v));
        else     x = int'(v);
        t = x * (1 << FIX);
        return t[BITS-1:0];
    endfunction

    function automatic int rev5(input int i);
        int r;
        int v;
        r = 0;
        v = i;
        for (int b = 0; b < 5; b++) begin
            r = r * 2 + (v % 2);
            v = v / 2;
        end
        return r;
    endfunction

    function automatic void push_frame();
        logic [FW-1:0] f0;
        logic [FW-1:0] f1;
        f0 = '0;
        f1 = '0;
        for (int i = 0; i < N; i++) begin
            f0[rev5(i)*2*BITS +: 2*BITS] = {16'h0000, conv(cur[i], 1'b0)};
            f1[i*2*BITS +: 2*BITS]       = {16'h0000, conv(cur[i], 1'b1)};
        end
        q0.push_back(f0);
        q1.push_back(f1);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cur.delete();
            q0.delete();
            q1.delete();
            m_full = 1'b0;
            m_err  = 1'b0;
        end else begin
            m_err = 1'b0;
            if (flush) begin
                cur.delete();
                m_full = 1'b0;
            end else if (m_full) begin
                if (frame_ready) m_full = 1'b0;
            end else if (s_valid) begin
                cur.push_back(s_data);
                if (cur.size() == N) begin
                    push_frame();
                    cur.delete();
                    m_full = 1'b1;
                end else if (s_last) begin
                    m_err = 1'b1;
                    cur.delete();
                end
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got %h exp %h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic cmp_frame(input string nm, input logic [FW-1:0] got, input logic [FW-1:0] exp);
        int k;
        checks++;
        if (got !== exp) begin
            failures++;
            k = 0;
            while (k < N - 1 && got[k*2*BITS +: 2*BITS] === exp[k*2*BITS +: 2*BITS]) k++;
            $display("FAIL %s slot %0d got %h exp %h at %0t", nm, k,
                     got[k*2*BITS +: 2*BITS], exp[k*2*BITS +: 2*BITS], $time);
        end
    endtask

    // ---------------- monitor ----------------
    logic [FW-1:0] exp0, exp1;
    bit            shown0, shown1, have0, have1;

    always @(negedge clk) begin
        chk("s_ready u0", {31'd0, r0}, {31'd0, !m_full});
        chk("s_ready u1", {31'd0, r1}, {31'd0, !m_full});
        chk("frame_valid u0", {31'd0, fv0}, {31'd0, m_full});
        chk("frame_valid u1", {31'd0, fv1}, {31'd0, m_full});
        chk("err u0", {31'd0, err0}, {31'd0, m_err});
        chk("err u1", {31'd0, err1}, {31'd0, m_err});

        if (fv0) begin
            if (!shown0) begin
                shown0 = 1'b1;
                have0  = (q0.size() != 0);
                if (have0) exp0 = q0.pop_front();
                else chk("frame u0 unexpected", 32'd1, 32'd0);
            end
            if (have0) cmp_frame("frame_data u0", fd0, exp0);
        end else begin
            shown0 = 1'b0;
        end

        if (fv1) begin
            if (!shown1) begin
                shown1 = 1'b1;
                have1  = (q1.size() != 0);
                if (have1) exp1 = q1.pop_front();
                else chk("frame u1 unexpected", 32'd1, 32'd0);
            end
            if (have1) cmp_frame("frame_data u1", fd1, exp1);
        end else begin
            shown1 = 1'b0;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic v, input logic [IN_W-1:0] d, input logic l,
                        input logic f, input logic fr);
        s_valid     = v;
        s_data      = d;
        s_last      = l;
        flush       = f;
        frame_ready = fr;
        @(negedge clk);
    endtask

    task automatic send(input logic [IN_W-1:0] d, input logic l, input logic fr);
        int guard;
        guard = 0;
        while (m_full && guard < 50) begin
            step(1'b0, '0, 1'b0, 1'b0, 1'b1);
            guard++;
        end
        if (guard >= 50) chk("send wait bound", 32'd1, 32'd0);
        step(1'b1, d, l, 1'b0, fr);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, " s_ready"}, {30'd0, r1, r0}, 32'd3);
        chk({nm, " frame_valid"}, {30'd0, fv1, fv0}, 32'd0);
        chk({nm, " err"}, {30'd0, err1, err0}, 32'd0);
        cmp_frame({nm, " frame_data u0"}, fd0, '0);
        cmp_frame({nm, " frame_data u1"}, fd1, '0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        checks      = 0;
        failures    = 0;
        s_valid     = 1'b0;
        s_data      = '0;
        s_last      = 1'b0;
        flush       = 1'b0;
        frame_ready = 1'b0;
        rst         = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // constant full-scale unsigned frame
        for (int i = 0; i < N; i++) send(8'hFF, 1'b0, 1'b1);
        idle(3);

        // index ramp exposes slot ordering; s_last on the final sample
        for (int i = 0; i < N; i++) send(8'(i), (i == N - 1), 1'b1);
        idle(3);

        // signed extremes then random fill
        send(8'h80, 1'b0, 1'b1);
        send(8'h7F, 1'b0, 1'b1);
        for (int i = 2; i < N; i++) send(8'($urandom), 1'b0, 1'b1);
        idle(2);

        // short frame: s_last on the 10th sample, then a full frame
        for (int i = 0; i < 10; i++) send(8'($urandom), (i == 9), 1'b1);
        idle(3);
        for (int i = 0; i < N; i++) send(8'($urandom), 1'b0, 1'b1);
        idle(2);

        // back-pressure: hold FULL for 5 cycles with s_valid high
        for (int i = 0; i < N; i++) send(8'($urandom), 1'b0, 1'b0);
        repeat (5) step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < N; i++) send(8'($urandom), 1'b0, 1'b1);
        idle(2);

        // flush after 7 samples, same cycle as a valid sample
        for (int i = 0; i < 7; i++) send(8'($urandom), 1'b0, 1'b1);
        step(1'b1, 8'h55, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < N; i++) send(8'($urandom), 1'b0, 1'b1);
        idle(2);

        // asynchronous reset mid-fill (20 samples) and mid-FULL
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < ((c == 0) ? 20 : N); i++) send(8'($urandom), 1'b0, 1'b0);
            #2 rst = 1'b1;
            #1 check_reset_outputs("async reset");
            @(negedge clk);
            rst = 1'b0;
            for (int i = 0; i < N; i++) send(8'($urandom), 1'b0, 1'b1);
            idle(2);
        end

        // random traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom % 4) != 0, 8'($urandom), ($urandom % 16) == 0,
                 ($urandom % 50) == 0, ($urandom % 3) != 0);
        end
        idle(5);
        chk("scoreboard drained", q0.size() + q1.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fft_in_buffer.md
FFT_IN_BUFFER -- requirements
Module: fft_in_buffer

Interface
REQ-001 Parameter N_POINTS, default 32, FFT frame length; SHALL be a power of two, 4..256.
REQ-002 Parameter IN_W, default 8, input sample width.
REQ-003 Parameter BITS, default 16, width of each real/imag fixed-point component.
REQ-004 Parameter FIX_BIT, default 7, fractional bits; IN_W+FIX_BIT SHALL be <= BITS-1 when SIGNED_IN=0 and <= BITS when SIGNED_IN=1.
REQ-005 Parameter SIGNED_IN, default 0: 0 = s_data is unsigned (zero-extended), 1 = s_data is two's complement (sign-extended).
REQ-006 Parameter BIT_REV, default 1: 1 = samples stored in bit-reversed slot order, 0 = natural order.
REQ-007 clk  in  1  single clock; all state changes on rising edge.
REQ-008 rst  in  1  asynchronous, active-high reset.
REQ-009 s_valid  in  1  input sample valid.
REQ-010 s_ready  out  1  block accepts a sample this cycle.
REQ-011 s_data  in  IN_W  input sample.
REQ-012 s_last  in  1  marks the last sample of a frame; qualified by s_valid&&s_ready.
REQ-013 flush  in  1  synchronous abort of the current frame.
REQ-014 frame_valid  out  1  complete frame held on frame_data.
REQ-015 frame_ready  in  1  FFT core consumes the frame.
REQ-016 frame_data  out  N_POINTS*2*BITS  slot k at bits [(k+1)*2*BITS-1 : k*2*BITS]; within a slot imag = upper BITS, real = lower BITS.
REQ-017 err  out  1  one-cycle pulse on a short frame.

Function
REQ-018 Conversion: real = extend(s_data) << FIX_BIT, truncated to BITS; imag = 0; extend per SIGNED_IN.
REQ-019 States: FILL and FULL; s_ready = (state==FILL), frame_valid = (state==FULL), both decoded from registered state.
REQ-020 FILL: on s_valid&&s_ready, the converted sample is written to slot bitrev(cnt) if BIT_REV=1, else slot cnt; cnt increments.
REQ-021 Accepting the sample with cnt==N_POINTS-1 SHALL clear cnt and enter FULL; frame_valid asserts on the next cycle. s_last on this sample is optional.
REQ-022 s_last accepted with cnt!=N_POINTS-1: sample is written, cnt clears, state stays FILL, and err pulses high for exactly one cycle on the next cycle. The partial frame is never presented.
REQ-023 FULL: s_ready=0; frame_data and all slots SHALL remain stable until frame_valid&&frame_ready.
REQ-024 frame_valid&&frame_ready returns the block to FILL; s_ready=1 on the next cycle, so at most one idle cycle occurs between frames.
REQ-025 frame_data is always driven from slot registers; slots are never cleared except by rst.
REQ-026 flush (either state): cnt=0, state FILL, err not pulsed. Flush has priority over a same-cycle sample or frame handshake, and that sample is discarded.
REQ-027 s_valid while s_ready=0 SHALL have no effect and raise no error.

Reset
REQ-028 rst asserted: state FILL, cnt 0, all slots 0, err 0, frame_valid 0, s_ready 1, effective immediately without waiting for a clock edge.
REQ-029 rst mid-fill or mid-FULL discards the frame; the first accepted sample after release goes to slot 0.

Verification
REQ-030 Defaults; 32 samples s_data=0xFF, frame_ready=1 -> frame_valid asserts the cycle after the 32nd sample; every slot = 0x00007F80; s_ready low for exactly one cycle.
REQ-031 SIGNED_IN=1; s_data=0x80 then 0x7F -> slot words 0x0000C000 and 0x00003F80.
REQ-032 BIT_REV=1, N=32, s_data=index 0..31 -> slot 16 holds sample 1 (0x00000080), slot 1 holds sample 16 (0x00000800); BIT_REV=0 -> slot k holds sample k.
REQ-033 s_last on the 10th sample -> err high for one cycle, frame_valid stays 0; the next 32 samples form a frame whose slot 0 holds the first new sample.
REQ-034 FULL with frame_ready=0 for 5 cycles while s_valid=1 -> s_ready=0, frame_data unchanged, no sample lost; the 6th-cycle handshake frees FILL.
REQ-035 rst pulse after 20 samples -> all outputs at reset values asynchronously; flush after 7 samples -> cnt restarts at 0, no err pulse.
